// File: rtl/sine_width_gen_if.sv
// sine_width_gen_if: tick/phase-step request side and pulse-width result side
// of the sine pulse-width source. The master drives ticks and phase steps; the
// slave (sine_width_gen) returns width, width_valid and wrap.
interface sine_width_gen_if #(
    parameter int PHASE_W = 16,
    parameter int WIDTH_W = 32
);
    logic               en;
    logic               tick;
    logic [PHASE_W-1:0] phase_inc;
    logic [WIDTH_W-1:0] width;
    logic               width_valid;
    logic               wrap;

    modport master (
        output en, tick, phase_inc,
        input  width, width_valid, wrap
    );

    modport slave (
        input  en, tick, phase_inc,
        output width, width_valid, wrap
    );
endinterface

// File: rtl/sine_width_gen.sv
// sine_width_gen: advances a phase accumulator on each accepted PWM tick and
// turns the captured phase into a pulse width in [0, PERIOD] through a
// quarter-wave sine ROM. Fixed latency of 3 cycles from the accepting edge.
// Build option: define SINE_WIDTH_CLAMP_EN to limit width to [1, PERIOD-1].
module sine_width_gen #(
    parameter int PERIOD     = 1000,
    parameter int PHASE_W    = 16,
    parameter int TABLE_BITS = 6,
    parameter int WIDTH_W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    sine_width_gen_if.slave bus
);
    localparam int HALF    = PERIOD / 2;
    localparam int TABLE_N = (1 << TABLE_BITS) + 1;
    localparam int IDX_W   = TABLE_BITS + 1;
    localparam int HALF_W  = $clog2(HALF + 1);
    localparam int PROD_W  = 15 + HALF_W;
    localparam int SUM_W   = PROD_W + 1;
    localparam int TOP_W   = TABLE_BITS + 2;
    localparam int FX      = 30;
    localparam longint PI_FX = 64'd3373259426;   // pi * 2^30

    if (PERIOD % 2 != 0 || PERIOD < 4) begin : g_bad_period
        $error("sine_width_gen: PERIOD must be even and at least 4");
    end
    if (PHASE_W < TABLE_BITS + 2) begin : g_bad_phase_w
        $error("sine_width_gen: PHASE_W must cover quadrant and table address bits");
    end

    // Quarter-wave table round(32767*sin(pi/2*i/2^TABLE_BITS)) built at
    // elaboration time with a fixed-point Taylor series, packed 15 bits/entry.
    function automatic logic [TABLE_N*15-1:0] build_rom();
        logic [TABLE_N*15-1:0] rom;
        longint x, x2, term, s, v;
        rom = '0;
        for (int i = 0; i < TABLE_N; i++) begin
            x    = (PI_FX * longint'(i)) >>> (TABLE_BITS + 1);
            x2   = (x * x) >>> FX;
            term = x;
            s    = x;
            for (int k = 1; k <= 8; k++) begin
                term = -((term * x2) >>> FX) / longint'((2 * k) * (2 * k + 1));
                s    = s + term;
            end
            v = (longint'(32767) * s + (longint'(1) <<< (FX - 1))) >>> FX;
            if (v > 32767) v = 32767;
            if (v < 0)     v = 0;
            rom[i*15 +: 15] = v[14:0];
        end
        return rom;
    endfunction

    localparam logic [TABLE_N*15-1:0] ROM_BITS = build_rom();

    // Rounded magnitude scaling to [0, HALF] and placement around mid-scale.
    function automatic logic [WIDTH_W-1:0] scale_width(input logic [14:0] mag,
                                                       input logic        neg);
        logic [SUM_W-1:0]  prod;
        logic [HALF_W:0]   d;
        prod = SUM_W'(mag) * SUM_W'(HALF) + SUM_W'(1 << 14);
        d    = prod[PROD_W:15];
        return neg ? (WIDTH_W'(HALF) - WIDTH_W'(d)) : (WIDTH_W'(HALF) + WIDTH_W'(d));
    endfunction

    // Keeps the PWM output from sitting at a constant level when enabled.
    function automatic logic [WIDTH_W-1:0] clamp_width(input logic [WIDTH_W-1:0] w);
`ifdef SINE_WIDTH_CLAMP_EN
        if (w < WIDTH_W'(1))
            return WIDTH_W'(1);
        else if (w > WIDTH_W'(PERIOD - 1))
            return WIDTH_W'(PERIOD - 1);
        else
            return w;
`else
        return w;
`endif
    endfunction

    logic [PHASE_W-1:0]    r_phase;
    logic                  r_vld_p0, r_vld_p1, r_vld_p2;
    logic                  r_wrap_p0, r_wrap_p1, r_wrap_p2;
    logic [TOP_W-1:0]      r_phase_p0;
    logic [IDX_W-1:0]      r_idx_p1;
    logic                  r_neg_p1, r_neg_p2;
    logic [14:0]           r_mag_p2;

    logic                  w_accept;
    logic [PHASE_W:0]      w_sum;
    logic [1:0]            w_q;
    logic [TABLE_BITS-1:0] w_a;
    logic [IDX_W-1:0]      w_idx;
    logic [14:0]           w_rom;
    logic [WIDTH_W-1:0]    w_width_p3;

    assign w_accept = bus.tick & bus.en;
    assign w_sum    = {1'b0, r_phase} + {1'b0, bus.phase_inc};

    // Stage 1: quadrant decode; odd quadrants read the table mirrored.
    assign w_q   = r_phase_p0[TOP_W-1 -: 2];
    assign w_a   = r_phase_p0[TABLE_BITS-1:0];
    assign w_idx = w_q[0] ? (IDX_W'(1 << TABLE_BITS) - {1'b0, w_a}) : {1'b0, w_a};

    // Stage 2: constant ROM lookup.
    assign w_rom = ROM_BITS[int'(r_idx_p1)*15 +: 15];

    // Stage 3: scale, sign and optional clamp.
    assign w_width_p3 = clamp_width(scale_width(r_mag_p2, r_neg_p2));

    // Control path: phase accumulator, valid/wrap pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase         <= '0;
            r_vld_p0        <= 1'b0;
            r_vld_p1        <= 1'b0;
            r_vld_p2        <= 1'b0;
            r_wrap_p0       <= 1'b0;
            r_wrap_p1       <= 1'b0;
            r_wrap_p2       <= 1'b0;
            bus.width       <= WIDTH_W'(HALF);
            bus.width_valid <= 1'b0;
            bus.wrap        <= 1'b0;
        end else begin
            if (w_accept)
                r_phase <= w_sum[PHASE_W-1:0];
            r_vld_p0        <= w_accept;
            r_wrap_p0       <= w_accept & w_sum[PHASE_W];
            r_vld_p1        <= r_vld_p0;
            r_wrap_p1       <= r_wrap_p0;
            r_vld_p2        <= r_vld_p1;
            r_wrap_p2       <= r_wrap_p1;
            bus.width_valid <= r_vld_p2;
            bus.wrap        <= r_vld_p2 & r_wrap_p2;
            if (r_vld_p2)
                bus.width <= w_width_p3;
        end
    end

    // Data path: pre-increment phase top bits, table index and magnitude.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_phase_p0 <= r_phase[PHASE_W-1 -: TOP_W];
        if (r_vld_p0) begin
            r_idx_p1 <= w_idx;
            r_neg_p1 <= w_q[1];
        end
        if (r_vld_p1) begin
            r_mag_p2 <= w_rom;
            r_neg_p2 <= r_neg_p1;
        end
    end
endmodule

// File: doc/sine_width_gen.md
# sine_width_gen

Upstream pulse-width source for the PWM sine generator. On every PWM period boundary (`tick` from the tick counter) it advances a phase accumulator. It then looks up a quarter-wave sine table, exploiting symmetry, and scales the result to a pulse width in `[0, PERIOD]`. The downstream comparator consumes `width` against its period counter. The block is fully pipelined and has a fixed latency of 3 cycles per tick.

## Interface
- `PERIOD`, 1000: PWM period in `clk` cycles. Must be even and ≥ 4. `HALF = PERIOD/2`.
- `PHASE_W`, 16: phase accumulator width.
- `TABLE_BITS`, 6: quarter-wave address bits. Table holds `2^TABLE_BITS + 1` entries.
- `WIDTH_W`, 32: output width bus size.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: gates acceptance of `tick`.
- `tick` in 1: one-cycle pulse marking a PWM period boundary.
- `phase_inc` in PHASE_W: phase step per accepted tick. Sampled on the accepted tick.
- `width` out WIDTH_W: current pulse width in cycles. Held between updates.
- `width_valid` out 1: one-cycle pulse when `width` updates.
- `wrap` out 1: one-cycle pulse, aligned with `width_valid`, when that sample's phase increment carried out of PHASE_W bits.

## Operation
- **Accept:** a tick is accepted when `tick && en` in the same cycle.
  - On accept, stage 0 captures the current `phase` (pre-increment).
  - In the same cycle, `phase <= phase + phase_inc` (mod `2^PHASE_W`). The carry-out is recorded as `wrap`.
- **Quadrant decode:**
  - `q = phase[PHASE_W-1:PHASE_W-2]`.
  - `a = phase[PHASE_W-3 -: TABLE_BITS]`.
  - Table index: `a` for q=0 and q=2; `2^TABLE_BITS - a` for q=1 and q=3.
  - Sign is negative for q=2 and q=3.
- **Table:** entry `i = round(32767·sin(π/2 · i/2^TABLE_BITS))`, 15-bit unsigned. Entry 0 = 0; entry `2^TABLE_BITS` = 32767. Implemented as constant ROM.
- **Scale:**
  - `d = (mag·HALF + 2^14) >> 15`, unsigned, with product width `15 + clog2(HALF+1)`.
  - `width = HALF + d` when positive, `HALF - d` when negative.
  - Result always lies in `[0, PERIOD]`.
- **Pipeline:** stage 1 = decode/index, stage 2 = ROM read (registered), stage 3 = scale/sign and output register.
- **Disabled:** with `en` low, ticks are ignored, `phase` holds, no `width_valid` is produced, and `width` holds. Samples already in the pipeline complete normally.
- **Back-to-back ticks:** each accepted tick, including ticks on consecutive cycles, yields exactly one `width_valid`, in order. There is no drop and no stall.
- **Mid-stream changes:** a change of `phase_inc` takes effect on the next accepted tick only.

## Timing
- **Reset values:** `phase = 0`, all pipeline valids = 0, `width = HALF`, `width_valid = 0`, `wrap = 0`.
- **Reset mid-operation:** asserting `rst_n` flushes all in-flight samples immediately. No `width_valid` is emitted for them.
- **Latency:** a tick accepted at edge N produces `width`/`width_valid`/`wrap` registered at edge N+3. `width` is stable from N+3 until the next update.
- **Downstream effect:** the comparator therefore sees the new width from cycle 3 of the period.
- **Tick + `en` falling together:** if `tick` coincides with `en` falling (both sampled in the same cycle), `en` low wins and the tick is not accepted.

## Configuration
- `SINE_WIDTH_CLAMP_EN`:
  - Defined: stage 3 clamps `width` to `[1, PERIOD-1]`, so PWM output never sits at constant 0 or 1 for a full period.
  - Undefined: no clamp; full range `[0, PERIOD]` is possible.
  - Latency is unchanged in both cases.

## Test plan
- **Reset:** hold `rst_n=0` for 5 cycles, then release with no tick → `width=500`, `width_valid=0`, `wrap=0` throughout.
- **Quarter steps:** `phase_inc=0x4000`, `en=1`, 4 ticks spaced 1000 cycles → `width` = 500, 1000, 500, 0, each with `width_valid` exactly 3 cycles after its tick. `wrap=1` only on the 4th.
- **Clamp:** same stimulus with `SINE_WIDTH_CLAMP_EN` defined → `width` = 500, 999, 500, 1.
- **Gating:** `en=0` with 3 ticks → no `width_valid`; `width` holds its last value. Then `en=1` with `phase_inc=0x4000` and a tick → next output continues from the held phase (e.g. 1000 after one prior tick).
- **Back-to-back:** `phase_inc=0x2000`, ticks on 3 consecutive cycles starting from phase 0 → 3 consecutive `width_valid` with `width` = 500, 854, 1000.
- **Reset mid-pipeline:** tick accepted, then `rst_n` low on the next cycle → no `width_valid` appears. After release, `width=500` and `phase=0`.
